// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC3 pipeline controller: opcodes, the mem_state
// encoding, the FSM state type and the opcode-class helper functions.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] MS_RD   = 2'd0;
    localparam logic [1:0] MS_WR   = 2'd1;
    localparam logic [1:0] MS_IND  = 2'd2;
    localparam logic [1:0] MS_IDLE = 2'd3;

    typedef enum logic [3:0] {
        S_FILL0,
        S_FILL1,
        S_FILL2,
        S_RUN,
        S_MEM_IND,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_EXIT,
        S_CTRL_WAIT
    } ctrl_state_e;

    function automatic logic is_alu(input logic [15:0] instr);
        return (instr[15:12] == OP_ADD) || (instr[15:12] == OP_AND) ||
               (instr[15:12] == OP_NOT) || (instr[15:12] == OP_LEA);
    endfunction

    function automatic logic is_load(input logic [15:0] instr);
        return (instr[15:12] == OP_LD) || (instr[15:12] == OP_LDR) ||
               (instr[15:12] == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [15:0] instr);
        return (instr[15:12] == OP_ST) || (instr[15:12] == OP_STR) ||
               (instr[15:12] == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [15:0] instr);
        return (instr[15:12] == OP_BR) || (instr[15:12] == OP_JMP);
    endfunction

endpackage

// File: rtl/lc3_controller_if.sv
// Control-out bus between the LC3 pipeline and its controller.
// master = controller side, slave = pipeline/datapath side.
interface lc3_controller_if;
    logic        complete_data;
    logic        complete_instr;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [15:0] IMem_dout;
    logic [2:0]  psr;

    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic [1:0]  mem_state;
    logic        br_taken;

    modport master (
        input  complete_data, complete_instr, IR, IR_Exec, IMem_dout, psr,
        output bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_updatePC, mem_state, br_taken
    );

    modport slave (
        output complete_data, complete_instr, IR, IR_Exec, IMem_dout, psr,
        input  bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_updatePC, mem_state, br_taken
    );
endinterface

// File: rtl/lc3_bypass_unit.sv
// Forwarding compare: flags when an operand of the instruction in decode
// (ir_i) is the destination of the ALU instruction that just executed.
module lc3_bypass_unit
    import lc3_ctrl_pkg::*;
(
    input  logic [15:0] ir_i,
    input  logic [15:0] ir_exec_i,
    input  logic        en_i,
    output logic        bypass_alu_1_o,
    output logic        bypass_alu_2_o,
    output logic        bypass_mem_1_o,
    output logic        bypass_mem_2_o
);

    logic [3:0] op;
    logic [2:0] dr;
    logic       src_ok;
    logic       unused_ir_bits;

    assign op             = ir_i[15:12];
    assign dr             = ir_exec_i[11:9];
    assign src_ok         = en_i && is_alu(ir_exec_i);
    assign unused_ir_bits = ^ir_i[4:3];

    // Register-number compare per operand slot, gated by producer class and state.
    always_comb begin
        bypass_alu_1_o = src_ok &&
                         ((op == OP_ADD) || (op == OP_AND) || (op == OP_NOT)) &&
                         (ir_i[8:6] == dr);
        bypass_alu_2_o = src_ok &&
                         ((op == OP_ADD) || (op == OP_AND)) &&
                         !ir_i[5] && (ir_i[2:0] == dr);
        bypass_mem_1_o = src_ok &&
                         ((op == OP_LDR) || (op == OP_STR)) &&
                         (ir_i[8:6] == dr);
        bypass_mem_2_o = src_ok &&
                         ((op == OP_ST) || (op == OP_STR) || (op == OP_STI)) &&
                         (ir_i[11:9] == dr);
    end

endmodule

// File: rtl/lc3_controller.sv
// LC3 pipeline controller: Moore FSM for stage enables and mem_state,
// combinational branch resolution and operand forwarding.
//
// state       | meaning
// FILL0       | pipeline empty, only fetch running
// FILL1       | fetch + decode running
// FILL2       | fetch + decode + execute running
// RUN         | all stages running
// MEM_IND     | pointer read for LDI/STI, pipeline frozen
// MEM_RD      | data read, pipeline frozen
// MEM_WR      | data write, pipeline frozen
// MEM_EXIT    | one-cycle resume; writeback only for loads
// CTRL_WAIT   | 3-cycle fetch/PC stall while a BR/JMP resolves
module lc3_controller
    import lc3_ctrl_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    lc3_controller_if.master        bus
);

    ctrl_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ld_q, ld_d;      // memory op in flight is a load

    logic [4:0]  en_vec;          // fetch, decode, execute, writeback, updatePC
    logic [1:0]  mem_state;
    logic        byp_en;
    logic        fill;
    logic [3:0]  exec_op;

    assign exec_op = bus.IR_Exec[15:12];

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_FILL0;
            cnt_q   <= 2'd0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
        end
    end

    // Next-state logic and Moore decode of enables / mem_state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_d      = ld_q;
        en_vec    = 5'b00000;
        mem_state = MS_IDLE;
        unique case (state_q)
            S_FILL0: begin
                en_vec  = 5'b10001;
                state_d = S_FILL1;
            end
            S_FILL1: begin
                en_vec  = 5'b11001;
                state_d = S_FILL2;
            end
            S_FILL2: begin
                en_vec  = 5'b11101;
                state_d = S_RUN;
            end
            S_RUN: begin
                en_vec = 5'b11111;
                // The opcode class is captured here; IR_Exec is not re-examined
                // for the load/store decision while the memory access is stalled.
                if (is_load(bus.IR_Exec) || is_store(bus.IR_Exec)) begin
                    ld_d = is_load(bus.IR_Exec);
                    if ((exec_op == OP_LDI) || (exec_op == OP_STI))
                        state_d = S_MEM_IND;
                    else if (is_load(bus.IR_Exec))
                        state_d = S_MEM_RD;
                    else
                        state_d = S_MEM_WR;
                end else if (is_ctrl(bus.IMem_dout) && bus.complete_instr) begin
                    state_d = S_CTRL_WAIT;
                    cnt_d   = 2'd2;
                end
            end
            S_MEM_IND: begin
                mem_state = MS_IND;
                if (bus.complete_data)
                    state_d = ld_q ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_state = MS_RD;
                if (bus.complete_data)
                    state_d = S_MEM_EXIT;
            end
            S_MEM_WR: begin
                mem_state = MS_WR;
                if (bus.complete_data)
                    state_d = S_MEM_EXIT;
            end
            S_MEM_EXIT: begin
                en_vec  = {3'b111, ld_q, 1'b1};
                state_d = S_RUN;
            end
            S_CTRL_WAIT: begin
                en_vec = 5'b01110;
                if (cnt_q == 2'd0)
                    state_d = S_RUN;
                else
                    cnt_d = cnt_q - 2'd1;
            end
            default: begin
                en_vec  = 5'b10001;
                state_d = S_FILL0;
            end
        endcase
    end

    assign fill   = (state_q == S_FILL0) || (state_q == S_FILL1) || (state_q == S_FILL2);
    assign byp_en = (state_q == S_RUN) || (state_q == S_MEM_EXIT);

    // Branch resolution on the instruction that just executed.
    always_comb begin
        bus.br_taken = 1'b0;
        if (!fill) begin
            if (exec_op == OP_JMP)
                bus.br_taken = 1'b1;
            else if (exec_op == OP_BR)
                bus.br_taken = |(bus.IR_Exec[11:9] & bus.psr);
        end
    end

    assign bus.enable_fetch     = en_vec[4];
    assign bus.enable_decode    = en_vec[3];
    assign bus.enable_execute   = en_vec[2];
    assign bus.enable_writeback = en_vec[1];
    assign bus.enable_updatePC  = en_vec[0];
    assign bus.mem_state        = mem_state;

    lc3_bypass_unit u_bypass (
        .ir_i           (bus.IR),
        .ir_exec_i      (bus.IR_Exec),
        .en_i           (byp_en),
        .bypass_alu_1_o (bus.bypass_alu_1),
        .bypass_alu_2_o (bus.bypass_alu_2),
        .bypass_mem_1_o (bus.bypass_mem_1),
        .bypass_mem_2_o (bus.bypass_mem_2)
    );

endmodule
